// File: rtl/alu_control_muldiv_pkg.sv
// Shared encodings for the EX-stage ALU decoder and the iterative multiply/divide unit.
// Pure constants and types, no logic.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ORI = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_NOP = 4'b1001;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_ORI  = 3'b101;
  localparam logic [2:0] OP_ANDI = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  // Order matches funct[1:0] of the arithmetic MD functs.
  typedef enum logic [1:0] {MULT, MULTU, DIV, DIVU} md_op_e;

endpackage

// File: rtl/alu_control_muldiv_if.sv
// EX-stage bus between control/regfile and the ALU control + mul/div block.
// master drives the instruction fields and operands; slave returns decode, HI/LO and stall.
interface alu_control_muldiv_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ALUOP_WIDTH = 3
);
  logic [ALUOP_WIDTH-1:0] ALUOp;
  logic [5:0]             ALUFunction;
  logic                   instr_valid;
  logic                   flush;
  logic [DATA_WIDTH-1:0]  rs_data;
  logic [DATA_WIDTH-1:0]  rt_data;
  logic [3:0]             ALUOperation;
  logic [DATA_WIDTH-1:0]  md_result;
  logic                   md_result_sel;
  logic [DATA_WIDTH-1:0]  hi;
  logic [DATA_WIDTH-1:0]  lo;
  logic                   md_busy;
  logic                   stall;

  modport master (
    output ALUOp, ALUFunction, instr_valid, flush, rs_data, rt_data,
    input  ALUOperation, md_result, md_result_sel, hi, lo, md_busy, stall
  );

  modport slave (
    input  ALUOp, ALUFunction, instr_valid, flush, rs_data, rt_data,
    output ALUOperation, md_result, md_result_sel, hi, lo, md_busy, stall
  );
endinterface

// File: rtl/alu_control_muldiv_md_datapath.sv
// Iterative mul/div datapath: one product/quotient bit per step, sign fix-up on the result.
// Operands latched on start; result valid after DATA_WIDTH steps; no backpressure of its own.
module md_datapath
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  step,
  input  md_op_e                op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] res_hi,
  output logic [DATA_WIDTH-1:0] res_lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  logic [CW-1:0] cnt_q;
  md_op_e        op_q;
  logic          sa_q, sb_q;
  logic [W-1:0]  amag_q, bmag_q, rs_q, acc_hi_q, acc_lo_q;

  logic         is_signed, is_div, is_div_q, a_neg, b_neg;
  logic [W-1:0] amag_in, bmag_in;
  logic [W:0]   mul_sum, div_shift, div_trial;

  assign is_signed = (op == MULT) || (op == DIV);
  assign is_div    = (op == DIV) || (op == DIVU);
  assign is_div_q  = (op_q == DIV) || (op_q == DIVU);
  assign a_neg     = is_signed & a[W-1];
  assign b_neg     = is_signed & b[W-1];
  assign amag_in   = a_neg ? -a : a;
  assign bmag_in   = b_neg ? -b : b;

  // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
  // divide keeps the remainder in acc_hi and shifts quotient bits into acc_lo.
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, amag_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[W-1]};
  assign div_trial = div_shift - {1'b0, bmag_q};

  assign last = (cnt_q == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      op_q     <= MULT;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      amag_q   <= '0;
      bmag_q   <= '0;
      rs_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
    end else if (start) begin
      cnt_q    <= '0;
      op_q     <= op;
      sa_q     <= a_neg;
      sb_q     <= b_neg;
      amag_q   <= amag_in;
      bmag_q   <= bmag_in;
      rs_q     <= a;
      acc_hi_q <= '0;
      acc_lo_q <= is_div ? amag_in : bmag_in;
    end else if (step) begin
      cnt_q <= cnt_q + CW'(1);
      if (is_div_q) begin
        if (!div_trial[W]) begin
          acc_hi_q <= div_trial[W-1:0];
          acc_lo_q <= {acc_lo_q[W-2:0], 1'b1};
        end else begin
          acc_hi_q <= div_shift[W-1:0];
          acc_lo_q <= {acc_lo_q[W-2:0], 1'b0};
        end
      end else begin
        acc_hi_q <= mul_sum[W:1];
        acc_lo_q <= {mul_sum[0], acc_lo_q[W-1:1]};
      end
    end
  end

  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   q_fix, r_fix;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;
  assign q_fix    = (sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q;
  assign r_fix    = sa_q ? -acc_hi_q : acc_hi_q;

  // Most-negative / -1 falls out naturally: magnitude quotient 2^(W-1) negates to itself.
  always_comb begin
    res_hi = prod_fix[2*W-1:W];
    res_lo = prod_fix[W-1:0];
    if (is_div_q) begin
      if (bmag_q == '0) begin
        res_hi = rs_q;
        res_lo = '1;
      end else begin
        res_hi = r_fix;
        res_lo = q_fix;
      end
    end
  end
endmodule

// File: rtl/alu_control_muldiv.sv
// ALU opcode decode plus HI/LO and the mul/div sequencer; ALUOperation is combinational.
// Mul/div takes DATA_WIDTH+1 cycles after the start edge; MD instructions stall while busy.
module alu_control_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int                     DATA_WIDTH  = 32,
  parameter int                     ALUOP_WIDTH = 3,
  parameter logic [ALUOP_WIDTH-1:0] RTYPE_CODE  = ALUOP_WIDTH'(3'b111)
) (
  input logic                 clk,
  input logic                 reset,
  alu_control_muldiv_if.slave bus
);
  logic [5:0]            funct;
  logic                  rtype, md_arith, md_any, busy, stall, start, mt_ok;
  logic [3:0]            alu_operation;
  logic [DATA_WIDTH-1:0] hi_q, lo_q, res_hi, res_lo, md_result;
  logic                  last;
  state_e                state_q, state_d;

  assign funct    = bus.ALUFunction;
  assign rtype    = (bus.ALUOp == RTYPE_CODE);
  assign md_arith = rtype && (funct[5:2] == 4'b0110);
  assign md_any   = md_arith || (rtype && (funct[5:2] == 4'b0100));
  assign busy     = (state_q != IDLE);
  assign stall    = bus.instr_valid & busy & md_any;
  assign start    = bus.instr_valid & md_arith & ~stall & ~bus.flush & (state_q == IDLE);
  assign mt_ok    = bus.instr_valid & rtype & ~stall;

  always_comb begin
    alu_operation = ALU_NOP;
    if (rtype) begin
      case (funct)
        F_AND:   alu_operation = ALU_AND;
        F_OR:    alu_operation = ALU_OR;
        F_ADD:   alu_operation = ALU_ADD;
        F_SUB:   alu_operation = ALU_SUB;
        F_NOR:   alu_operation = ALU_NOR;
        F_SLT:   alu_operation = ALU_SLT;
        default: alu_operation = ALU_NOP;
      endcase
    end else if (bus.ALUOp == ALUOP_WIDTH'(OP_ADDI)) begin
      alu_operation = ALU_ADD;
    end else if (bus.ALUOp == ALUOP_WIDTH'(OP_ORI)) begin
      alu_operation = ALU_ORI;
    end else if (bus.ALUOp == ALUOP_WIDTH'(OP_ANDI)) begin
      alu_operation = ALU_AND;
    end
  end

  always_comb begin
    md_result = '0;
    if (rtype && funct == F_MFHI) md_result = hi_q;
    if (rtype && funct == F_MFLO) md_result = lo_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (bus.flush) state_d = IDLE;
               else if (last) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  md_datapath #(.DATA_WIDTH(DATA_WIDTH)) u_dp (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .step   (state_q == RUN),
    .op     (md_op_e'(funct[1:0])),
    .a      (bus.rs_data),
    .b      (bus.rt_data),
    .last   (last),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // mthi/mtlo cannot collide with the FIX write: they are stalled while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == FIX) begin
      if (!bus.flush) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end else begin
      if (mt_ok && funct == F_MTHI) hi_q <= bus.rs_data;
      if (mt_ok && funct == F_MTLO) lo_q <= bus.rs_data;
    end
  end

  assign bus.ALUOperation  = alu_operation;
  assign bus.md_result     = md_result;
  assign bus.md_result_sel = bus.instr_valid & rtype & ((funct == F_MFHI) || (funct == F_MFLO)) & ~stall;
  assign bus.hi            = hi_q;
  assign bus.lo            = lo_q;
  assign bus.md_busy       = busy;
  assign bus.stall         = stall;
endmodule

// File: tb/tb_alu_control_muldiv.sv
// Directed + randomized bench for alu_control_muldiv; mul/div results come from plain
// 64-bit arithmetic, latency from the stated DATA_WIDTH+1 busy window.
module tb_alu_control_muldiv;
  localparam logic [5:0] T_MULT = 6'b011000, T_MULTU = 6'b011001, T_DIV = 6'b011010;
  localparam logic [5:0] T_DIVU = 6'b011011, T_MFHI = 6'b010000, T_MTHI = 6'b010001;
  localparam logic [5:0] T_MFLO = 6'b010010, T_MTLO = 6'b010011, T_ADD = 6'b100000;
  localparam int LAT = 33;

  logic clk, reset;
  int   errors, checks;
  logic [31:0] exp_hi, exp_lo;

  alu_control_muldiv_if #(.DATA_WIDTH(32), .ALUOP_WIDTH(3)) bus();

  alu_control_muldiv #(.DATA_WIDTH(32), .ALUOP_WIDTH(3), .RTYPE_CODE(3'b111)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic void ref_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    p  = '0;
    eh = '0;
    el = '0;
    if (fn == T_MULT || fn == T_MULTU) begin
      if (fn == T_MULT) p = longint'(sa) * longint'(sb);
      else              p = {32'b0, a} * {32'b0, b};
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
      el = 32'hFFFF_FFFF;
      eh = a;
    end else if (fn == T_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        el = 32'h8000_0000;
        eh = 32'd0;
      end else begin
        el = sa / sb;
        eh = sa % sb;
      end
    end else begin
      el = a / b;
      eh = a % b;
    end
  endfunction

  task automatic drive(input logic [2:0] op, input logic [5:0] fn, input logic iv,
                       input logic [31:0] a, input logic [31:0] b);
    bus.ALUOp       = op;
    bus.ALUFunction = fn;
    bus.instr_valid = iv;
    bus.rs_data     = a;
    bus.rt_data     = b;
  endtask

  // Leaves the bench at the first negedge after the start edge.
  task automatic start_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive(3'b111, fn, 1'b1, a, b);
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [5:0] fn,
                               input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int cnt;
    ref_md(fn, a, b, eh, el);
    start_md(fn, a, b);
    cnt = 0;
    while (bus.md_busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cnt), 64'(LAT));
    check({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    check({tag, "_lo"}, 64'(bus.lo), 64'(el));
    exp_hi = eh;
    exp_lo = el;
    drive(3'b111, T_MFHI, 1'b1, 32'd0, 32'd0);
    #1;
    check({tag, "_mfhi"}, 64'(bus.md_result), 64'(eh));
    bus.instr_valid = 1'b0;
  endtask

  logic [2:0]  dop  [12];
  logic [5:0]  dfn  [12];
  logic [3:0]  dexp [12];
  logic [5:0]  rfn;
  logic [31:0] ra, rb;

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus.flush = 1'b0;
    drive(3'b111, T_MULT, 1'b1, 32'h5, 32'h6);
    #12;
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.md_busy), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.instr_valid = 1'b0;

    dop[0]  = 3'b111; dfn[0]  = 6'b100100; dexp[0]  = 4'b0000;
    dop[1]  = 3'b111; dfn[1]  = 6'b100010; dexp[1]  = 4'b0111;
    dop[2]  = 3'b111; dfn[2]  = 6'b000000; dexp[2]  = 4'b1001;
    dop[3]  = 3'b110; dfn[3]  = 6'b000000; dexp[3]  = 4'b0011;
    dop[4]  = 3'b111; dfn[4]  = 6'b100101; dexp[4]  = 4'b0001;
    dop[5]  = 3'b111; dfn[5]  = 6'b100000; dexp[5]  = 4'b0011;
    dop[6]  = 3'b111; dfn[6]  = 6'b100111; dexp[6]  = 4'b0100;
    dop[7]  = 3'b111; dfn[7]  = 6'b101010; dexp[7]  = 4'b1000;
    dop[8]  = 3'b101; dfn[8]  = 6'b100100; dexp[8]  = 4'b0010;
    dop[9]  = 3'b100; dfn[9]  = 6'b000000; dexp[9]  = 4'b0000;
    dop[10] = 3'b000; dfn[10] = 6'b100000; dexp[10] = 4'b1001;
    dop[11] = 3'b111; dfn[11] = 6'b011000; dexp[11] = 4'b1001;
    for (int i = 0; i < 12; i++) begin
      drive(dop[i], dfn[i], 1'b0, 32'd0, 32'd0);
      #1;
      check($sformatf("decode_%0d", i), 64'(bus.ALUOperation), 64'(dexp[i]));
    end
    check("post_rst_busy", 64'(bus.md_busy), 64'd0);

    run_and_check("multu_max", T_MULTU, 32'hFFFF_FFFF, 32'h2);
    run_and_check("div_neg7", T_DIV, 32'hFFFF_FFF9, 32'h2);
    run_and_check("divu_zero", T_DIVU, 32'h1234_5678, 32'h0);
    run_and_check("div_zero_neg", T_DIV, 32'h8765_4321, 32'h0);

    // mflo issued while a mult runs stalls until the result lands
    ref_md(T_MULT, 32'd1000, 32'hFFFF_FFFD, exp_hi, exp_lo);
    start_md(T_MULT, 32'd1000, 32'hFFFF_FFFD);
    drive(3'b111, T_ADD, 1'b1, 32'd0, 32'd0);
    #1;
    check("alu_no_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    drive(3'b111, T_MFLO, 1'b1, 32'd0, 32'd0);
    for (int k = 3; k <= LAT; k++) begin
      #1;
      check($sformatf("mflo_stall_k%0d", k), 64'(bus.stall), 64'd1);
      check($sformatf("mflo_sel_k%0d", k), 64'(bus.md_result_sel), 64'd0);
      @(negedge clk);
    end
    #1;
    check("mflo_stall_end", 64'(bus.stall), 64'd0);
    check("mflo_sel_end", 64'(bus.md_result_sel), 64'd1);
    check("mflo_result", 64'(bus.md_result), 64'(exp_lo));
    bus.ALUFunction = T_MFHI;
    #1;
    check("mfhi_result", 64'(bus.md_result), 64'(exp_hi));
    bus.instr_valid = 1'b0;

    // flush mid-RUN
    start_md(T_MULT, 32'd5, 32'd7);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.md_busy), 64'd0);
    check("flush_hi", 64'(bus.hi), 64'(exp_hi));
    check("flush_lo", 64'(bus.lo), 64'(exp_lo));
    drive(3'b111, T_MTHI, 1'b1, 32'h1234, 32'd0);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("mthi", 64'(bus.hi), 64'h1234);
    drive(3'b111, T_MTLO, 1'b1, 32'hCAFE_F00D, 32'd0);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("mtlo", 64'(bus.lo), 64'hCAFE_F00D);
    exp_hi = 32'h1234;
    exp_lo = 32'hCAFE_F00D;

    // flush on the start edge drops the start
    drive(3'b111, T_MULTU, 1'b1, 32'd3, 32'd4);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.flush = 1'b0;
    check("flush_start_busy", 64'(bus.md_busy), 64'd0);

    // flush in FIX suppresses the write
    start_md(T_MULTU, 32'd3, 32'd4);
    repeat (LAT - 1) @(negedge clk);
    check("fix_busy_before", 64'(bus.md_busy), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("fix_flush_busy", 64'(bus.md_busy), 64'd0);
    check("fix_flush_hi", 64'(bus.hi), 64'(exp_hi));
    check("fix_flush_lo", 64'(bus.lo), 64'(exp_lo));

    // async reset mid-RUN
    start_md(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_hi", 64'(bus.hi), 64'd0);
    check("arst_lo", 64'(bus.lo), 64'd0);
    check("arst_busy", 64'(bus.md_busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_and_check("div_ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int i = 0; i < 16; i++) begin
      rfn = T_MULT | 6'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      else if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 30);
      run_and_check($sformatf("rand_%0d", i), rfn, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
